// File: rtl/line_buffer_ring_if.sv
// Bus between the draw engine / pixel readout and the line buffer ring.
// master drives addresses, data and flips; slave is the ring itself.
interface line_buffer_ring_if #(
  parameter int NUM_BUFS    = 2,
  parameter int COLOUR_W    = 9,
  parameter int LANES       = 8,
  parameter int LINE_PIXELS = 4096
);
  localparam int DEPTH = LINE_PIXELS / LANES;
  localparam int PA_W  = $clog2(LINE_PIXELS);
  localparam int WA_W  = $clog2(DEPTH);
  localparam int BS_W  =
    ($clog2(NUM_BUFS) > 1) ? $clog2(NUM_BUFS) : 1;

  logic [PA_W-1:0]           rd_addr;
  logic [COLOUR_W-1:0]       rd_colour;
  logic [WA_W-1:0]           wr_addr;
  logic [LANES-1:0]          wr_we;
  logic [LANES*COLOUR_W-1:0] wr_colour;
  logic                      wr_ready;
  logic                      flip_req;
  logic                      flip_ack;
  logic                      busy;
  logic [COLOUR_W-1:0]       clear_colour;
  logic [BS_W-1:0]           on_sel;
  logic [BS_W-1:0]           off_sel;

  modport master (
    output rd_addr, wr_addr, wr_we, wr_colour,
    output flip_req, clear_colour,
    input  rd_colour, wr_ready, flip_ack,
    input  busy, on_sel, off_sel
  );

  modport slave (
    input  rd_addr, wr_addr, wr_we, wr_colour,
    input  flip_req, clear_colour,
    output rd_colour, wr_ready, flip_ack,
    output busy, on_sel, off_sel
  );
endinterface

// File: rtl/line_buffer_ring.sv
// N-deep ring of line buffers: lane-masked word writes, pixel reads.
// LINEBUF_AUTOCLEAR_EN builds the engine that clears retired buffers.
module line_buffer_ring #(
  parameter int NUM_BUFS    = 2,
  parameter int COLOUR_W    = 9,
  parameter int LANES       = 8,
  parameter int LINE_PIXELS = 4096
) (
  input logic               clk_draw,
  input logic               rst_draw,
  line_buffer_ring_if.slave bus
);
  localparam int DEPTH = LINE_PIXELS / LANES;
  localparam int PA_W  = $clog2(LINE_PIXELS);
  localparam int WA_W  = $clog2(DEPTH);
  localparam int LS_W  = $clog2(LANES);
  localparam int BS_W  =
    ($clog2(NUM_BUFS) > 1) ? $clog2(NUM_BUFS) : 1;

  logic [COLOUR_W-1:0] ram [NUM_BUFS][DEPTH][LANES];

  logic [BS_W-1:0]     on_sel;
  logic [BS_W-1:0]     off_sel;
  logic [BS_W-1:0]     nxt_sel;
  logic                flip_ack;
  logic                busy;
  logic                wr_ready;
  logic [COLOUR_W-1:0] rd_colour;
  logic [WA_W-1:0]     rd_word;
  logic [LS_W-1:0]     rd_lane;

  assign rd_word = bus.rd_addr[PA_W-1:LS_W];
  assign rd_lane = bus.rd_addr[LS_W-1:0];

  assign nxt_sel = (off_sel == BS_W'(NUM_BUFS - 1))
                 ? '0 : off_sel + 1'b1;

`ifdef LINEBUF_AUTOCLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [BS_W-1:0] clr_buf;
  logic [WA_W-1:0] clr_addr;
  logic            clr_act;

  // Flip handshake and clear sequencer; flips wait for the clear
  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      state    <= IDLE;
      on_sel   <= '0;
      off_sel  <= BS_W'(1);
      clr_buf  <= '0;
      clr_addr <= '0;
      flip_ack <= 1'b0;
      busy     <= 1'b0;
    end else begin
      flip_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.flip_req) begin
            flip_ack <= 1'b1;
            on_sel   <= off_sel;
            off_sel  <= nxt_sel;
            clr_buf  <= on_sel;
            clr_addr <= '0;
            busy     <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == WA_W'(DEPTH - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clr_act  = (state == CLEAR);
  assign wr_ready = !(busy && (clr_buf == off_sel));
`else
  logic unused_clr;

  // Without a clear engine every request flips immediately
  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      on_sel   <= '0;
      off_sel  <= BS_W'(1);
      flip_ack <= 1'b0;
    end else begin
      flip_ack <= bus.flip_req;
      if (bus.flip_req) begin
        on_sel  <= off_sel;
        off_sel <= nxt_sel;
      end
    end
  end

  assign busy       = 1'b0;
  assign wr_ready   = 1'b1;
  assign unused_clr = ^bus.clear_colour;
`endif

  // Draw writes and clear writes land in different buffers
  always_ff @(posedge clk_draw) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_ready && bus.wr_we[k])
        ram[off_sel][bus.wr_addr][k] <=
          bus.wr_colour[(LANES-k)*COLOUR_W-1 -: COLOUR_W];
`ifdef LINEBUF_AUTOCLEAR_EN
      if (clr_act)
        ram[clr_buf][clr_addr][k] <= bus.clear_colour;
`endif
    end
  end

  // One-cycle pixel read from the buffer on screen this cycle
  always_ff @(posedge clk_draw) begin
    if (rst_draw)
      rd_colour <= '0;
    else
      rd_colour <= ram[on_sel][rd_word][rd_lane];
  end

  assign bus.rd_colour = rd_colour;
  assign bus.wr_ready  = wr_ready;
  assign bus.flip_ack  = flip_ack;
  assign bus.busy      = busy;
  assign bus.on_sel    = on_sel;
  assign bus.off_sel   = off_sel;
endmodule

// File: tb/tb_line_buffer_ring.sv
// Bench for line_buffer_ring: scoreboarded pixel reads plus
// directed flip/clear/reset checks on 2- and 3-buffer rings.
module tb_line_buffer_ring;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  line_buffer_ring_if #(
    .NUM_BUFS(2), .COLOUR_W(9),
    .LANES(8), .LINE_PIXELS(64)
  ) b ();

  line_buffer_ring_if #(
    .NUM_BUFS(3), .COLOUR_W(9),
    .LANES(8), .LINE_PIXELS(64)
  ) b3 ();

  line_buffer_ring #(
    .NUM_BUFS(2), .COLOUR_W(9),
    .LANES(8), .LINE_PIXELS(64)
  ) dut (
    .clk_draw(clk),
    .rst_draw(rst),
    .bus(b.slave)
  );

  line_buffer_ring #(
    .NUM_BUFS(3), .COLOUR_W(9),
    .LANES(8), .LINE_PIXELS(64)
  ) dut3 (
    .clk_draw(clk),
    .rst_draw(rst),
    .bus(b3.slave)
  );

  int checks = 0;
  int errors = 0;

  logic       rd_v   = 1'b0;
  logic       rd_v_q = 1'b0;
  logic [8:0] exp_q[$];
  int         pix_q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Read monitor: a read issued before an edge is checked after it
  always @(posedge clk) rd_v_q <= rd_v;

  always @(negedge clk) begin
    if (rd_v_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_sb: no expected entry");
      end else begin
        logic [8:0] e;
        int         p;
        e = exp_q.pop_front();
        p = pix_q.pop_front();
        checks++;
        if (b.rd_colour !== e) begin
          errors++;
          $display("FAIL rd_pix%0d: got %0h expected %0h",
                   p, b.rd_colour, e);
        end
      end
    end
  end

  task automatic rd_pix(input int p, input logic [8:0] e);
    b.rd_addr = 6'(p);
    rd_v      = 1'b1;
    exp_q.push_back(e);
    pix_q.push_back(p);
    tick();
  endtask

  task automatic rd_end();
    rd_v = 1'b0;
    tick();
  endtask

  task automatic wr_word(input int a,
                         input logic [7:0] we,
                         input logic [71:0] d);
    chk("wr_ready_idle", b.wr_ready, 1);
    b.wr_addr   = 3'(a);
    b.wr_we     = we;
    b.wr_colour = d;
    tick();
    b.wr_we = '0;
  endtask

  task automatic flip(input string nm);
    b.flip_req = 1'b1;
    tick();
    b.flip_req = 1'b0;
    chk({nm, "_ack"}, b.flip_ack, 1);
  endtask

  task automatic wait_clear(input string nm,
                            input int exp_n);
    int n;
    n = 0;
    while (b.busy && n < 40) begin
      n++;
      tick();
    end
    chk(nm, n, exp_n);
  endtask

  initial begin
    logic [71:0] d;
    int n;
    b.rd_addr       = '0;
    b.wr_addr       = '0;
    b.wr_we         = '0;
    b.wr_colour     = '0;
    b.flip_req      = 1'b0;
    b.clear_colour  = 9'h1FF;
    b3.rd_addr      = '0;
    b3.wr_addr      = '0;
    b3.wr_we        = '0;
    b3.wr_colour    = '0;
    b3.flip_req     = 1'b0;
    b3.clear_colour = 9'h1FF;

    repeat (3) tick();
    chk("rst_on",     b.on_sel, 0);
    chk("rst_off",    b.off_sel, 1);
    chk("rst_busy",   b.busy, 0);
    chk("rst_ack",    b.flip_ack, 0);
    chk("rst_rd",     b.rd_colour, 0);
    chk("rst_off3",   b3.off_sel, 1);
    rst = 1'b0;
    tick();

    // Word 3 lanes 1..8 into buffer 1, then show it
    for (int k = 0; k < 8; k++)
      d[(8-k)*9-1 -: 9] = 9'(k + 1);
    wr_word(3, 8'hFF, d);
    flip("t1_flip");
    chk("t1_on",  b.on_sel, 1);
    chk("t1_off", b.off_sel, 0);
`ifdef LINEBUF_AUTOCLEAR_EN
    chk("t1_wr_blocked", b.wr_ready, 0);
    wait_clear("t1_busy_len", 8);
`else
    chk("t1_busy", b.busy, 0);
    chk("t1_wr_ready", b.wr_ready, 1);
`endif
    for (int k = 0; k < 8; k++)
      rd_pix(24 + k, 9'(k + 1));
    rd_end();

    // Word 0: full 0x0AA then lanes 0 and 7 to 0x155
    for (int k = 0; k < 8; k++)
      d[(8-k)*9-1 -: 9] = 9'h0AA;
    wr_word(0, 8'hFF, d);
    for (int k = 0; k < 8; k++)
      d[(8-k)*9-1 -: 9] = 9'h155;
    wr_word(0, 8'b1000_0001, d);
    flip("t2_flip");
    chk("t2_on",  b.on_sel, 0);
    chk("t2_off", b.off_sel, 1);
`ifdef LINEBUF_AUTOCLEAR_EN
    wait_clear("t2_busy_len", 8);
`endif
    rd_pix(0, 9'h155);
    for (int k = 1; k < 7; k++)
      rd_pix(k, 9'h0AA);
    rd_pix(7, 9'h155);
`ifdef LINEBUF_AUTOCLEAR_EN
    for (int p = 8; p < 64; p++)
      rd_pix(p, 9'h1FF);
`endif
    rd_end();

`ifdef LINEBUF_AUTOCLEAR_EN
    // Buffer 1 was cleared by the last flip: all 0x1FF
    flip("t3_flip");
    chk("t3_on", b.on_sel, 1);
    wait_clear("t3_busy_len", 8);
    for (int p = 0; p < 64; p++)
      rd_pix(p, 9'h1FF);
    rd_end();

    // Held flip request: second ack waits for the clear
    b.flip_req = 1'b1;
    tick();
    chk("t4_ack0", b.flip_ack, 1);
    chk("t4_on0",  b.on_sel, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_busy", b.busy, 1);
      chk("t4_wr_blocked", b.wr_ready, 0);
      if (i > 0)
        chk("t4_no_ack", b.flip_ack, 0);
      tick();
    end
    chk("t4_busy_fall", b.busy, 0);
    chk("t4_no_ack_idle", b.flip_ack, 0);
    tick();
    b.flip_req = 1'b0;
    chk("t4_ack1", b.flip_ack, 1);
    chk("t4_on1",  b.on_sel, 1);
    wait_clear("t4_busy_len", 8);
`else
    // Back-to-back flips alternate every cycle
    b.flip_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_b2b_ack", b.flip_ack, 1);
      chk("t4_b2b_on", b.on_sel, 32'((i + 1) % 2));
    end
    b.flip_req = 1'b0;
    tick();
    chk("t4_ack_drop", b.flip_ack, 0);
    chk("t4_busy", b.busy, 0);
`endif

    // Three-buffer ring rotates 0->1->2->0
    for (int f = 0; f < 3; f++) begin
      b3.flip_req = 1'b1;
      tick();
      b3.flip_req = 1'b0;
      chk("t5_ack", b3.flip_ack, 1);
      chk("t5_on",  b3.on_sel, 32'((f + 1) % 3));
      chk("t5_off", b3.off_sel, 32'((f + 2) % 3));
      n = 0;
      while (b3.busy && n < 40) begin
        chk("t5_wr_ready", b3.wr_ready, 1);
        n++;
        tick();
      end
`ifdef LINEBUF_AUTOCLEAR_EN
      chk("t5_busy_len", n, 8);
`else
      chk("t5_busy_len", n, 0);
`endif
    end

    // Reset in the middle of a clear
    flip("t6_flip");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t6_busy", b.busy, 0);
    chk("t6_on",   b.on_sel, 0);
    chk("t6_off",  b.off_sel, 1);
    chk("t6_ack",  b.flip_ack, 0);
    chk("t6_rd",   b.rd_colour, 0);
    rst = 1'b0;
    tick();
    chk("t6_idle_busy", b.busy, 0);

    repeat (2) tick();
    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
